// File: rtl/mult_pkg.sv
// mult_pkg: shared defaults, accumulator width derivation and FSM state type for mult_accumulator
package mult_pkg;
  localparam int N_DEF = 32;
  localparam int G_DEF = 8;
  localparam int CW_DEF = 16;
  typedef logic state_t;
  localparam state_t ACC = 1'b0;
  localparam state_t HOLD = 1'b1;
  function automatic int acc_width(input int n, input int g);
    return 2 * n + g;
  endfunction
endpackage

// File: rtl/mult_accumulator_sat_add.sv
// sat_add: AW-bit signed adder with overflow detect; ports a_i, b_i (addends), sum_o, ovf_o; clamps on overflow when MULT_ACC_SATURATE_EN is defined, wraps otherwise
module sat_add #(
  parameter int AW = 72
) (
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic [AW-1:0] sum_o,
  output logic          ovf_o
);
  logic [AW-1:0] raw;
  always_comb begin
    raw = a_i + b_i;
    ovf_o = (a_i[AW-1] == b_i[AW-1]) && (raw[AW-1] != a_i[AW-1]);
`ifdef MULT_ACC_SATURATE_EN
    sum_o = !ovf_o ? raw : a_i[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`else
    sum_o = raw;
`endif
  end
endmodule

// File: rtl/mult_accumulator.sv
// mult_accumulator: accumulates signed Booth products into groups; ports clk, rst, in_valid/in_ready/product/in_last (input stream), out_valid/out_ready/acc_out/term_cnt/overflow (result); macro MULT_ACC_SATURATE_EN selects clamping adds
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int G = G_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*N-1:0]               product,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [acc_width(N, G)-1:0]   acc_out,
  output logic [CW-1:0]                term_cnt,
  output logic                         overflow
);
  localparam int AW = acc_width(N, G);
  state_t state_q, state_d;
  logic [AW-1:0] sum_q, sum_d, res_q, res_d, ext, add_sum;
  logic [CW-1:0] cnt_q, cnt_d, tc_q, tc_d, cnt_inc;
  logic ovf_q, ovf_d, ovo_q, ovo_d, add_ovf, beat, grp_end;
  assign ext = AW'($signed(product));
  sat_add #(.AW(AW)) u_add (
    .a_i  (sum_q),
    .b_i  (ext),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );
  assign in_ready = state_q == ACC;
  assign out_valid = state_q == HOLD;
  assign acc_out = res_q;
  assign term_cnt = tc_q;
  assign overflow = ovo_q;
  always_comb begin
    beat = in_valid && in_ready;
    grp_end = beat && in_last;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CW'(1);
    sum_d = grp_end ? '0 : beat ? add_sum : sum_q;
    cnt_d = grp_end ? '0 : beat ? cnt_inc : cnt_q;
    ovf_d = !grp_end && (ovf_q || (beat && add_ovf));
    res_d = grp_end ? add_sum : res_q;
    tc_d = grp_end ? cnt_inc : tc_q;
    ovo_d = grp_end ? (ovf_q || add_ovf) : ovo_q;
    state_d = grp_end ? HOLD : (out_valid && out_ready) ? ACC : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      sum_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      res_q <= '0;
      tc_q <= '0;
      ovo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      res_q <= res_d;
      tc_q <= tc_d;
      ovo_q <= ovo_d;
    end
  end
endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 SHALL have parameter N, default 32: operand width of the upstream Booth multiplier; the product is 2N bits.
REQ-002 SHALL have parameter G, default 8: accumulator guard bits, legal range 0..16; AW = 2N+G.
REQ-003 SHALL have parameter CW, default 16: term-counter width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  a product term is present.
REQ-007 in_ready  output  1  block accepts a term this cycle.
REQ-008 product  input  2N  signed two's-complement product from the Booth multiplier.
REQ-009 in_last  input  1  the term is the final one of an accumulation group.
REQ-010 out_valid  output  1  result is held for the consumer.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 acc_out  output  AW  signed group sum.
REQ-013 term_cnt  output  CW  number of terms in the group.
REQ-014 overflow  output  1  sticky flag: a signed AW-bit overflow occurred in the group.

Function
REQ-015 SHALL implement a two-state FSM, ACC and HOLD; the reset state is ACC.
REQ-016 in_ready SHALL be 1 in ACC and 0 in HOLD; a beat is accepted when in_valid && in_ready.
REQ-017 On an accepted beat, the running sum SHALL update to sum + sign-extend(product to AW); the running count SHALL update to count+1, saturating at 2^CW-1.
REQ-018 An accepted beat with in_last=1 SHALL:
- load acc_out, term_cnt and overflow with values that include that beat;
- clear the running sum, count and overflow;
- transition to HOLD.
REQ-019 out_valid SHALL be 1 exactly while in HOLD; latency is one cycle from acceptance of the last beat to out_valid=1.
REQ-020 In HOLD, acc_out, term_cnt and overflow SHALL stay stable until out_valid && out_ready; on that cycle the FSM SHALL return to ACC.
REQ-021 in_valid in HOLD SHALL be ignored, and the term SHALL NOT be accumulated; upstream holds it.
REQ-022 A single-term group (first beat has in_last=1) SHALL produce acc_out = sign-extended product and term_cnt = 1.
REQ-023 Overflow SHALL be detected as both addends having equal sign while the AW-bit sum has the opposite sign; the flag stays set for the rest of the group.
REQ-024 Output registers SHALL hold their previous values while in ACC; only out_valid qualifies them.

Reset
REQ-025 rst=1 at a clock edge SHALL force:
- ACC state;
- running sum, count and overflow to 0;
- acc_out, term_cnt and overflow outputs to 0;
- out_valid=0.
REQ-026 rst SHALL dominate in_valid/out_ready in the same cycle; a group in progress or a held result SHALL be discarded without completion.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 With macro MULT_ACC_SATURATE_EN defined, an overflowing add SHALL clamp the sum to 2^(AW-1)-1 (positive overflow) or -2^(AW-1) (negative overflow), and later terms SHALL add to the clamped value.
REQ-029 Without MULT_ACC_SATURATE_EN, the sum SHALL wrap modulo 2^AW; the overflow flag behaves identically in both builds.

Structure
REQ-030 Package mult_pkg SHALL hold:
- default N, G and CW constants;
- the AW derivation;
- the ACC/HOLD state type.
REQ-031 A single sub-module, sat_add, SHALL hold the AW-bit signed adder, the overflow detect and the macro-controlled clamp; the FSM and registers stay in mult_accumulator.

Verification
REQ-032 Two-term group: 2614916801295 then 1165763863 (last) -> acc_out=2616082565158, term_cnt=2, overflow=0, out_valid one cycle after the last beat.
REQ-033 Signed group: -2008 then -263875 (last) -> acc_out=-265883, term_cnt=2; then positive x negative product -4611686016279904256 alone (last) -> acc_out=-4611686016279904256, term_cnt=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no term absorbed; out_ready=1 -> return to ACC, the next term starts a fresh group.
REQ-035 Overflow with G=0, N=32: 2^63-1 then 1 (last) -> overflow=1; acc_out=2^63-1 with MULT_ACC_SATURATE_EN, -2^63 without.
REQ-036 Reset mid-group: accept 123456789, assert rst for 1 cycle, then 0 (last) -> acc_out=0, term_cnt=1; rst while in HOLD -> out_valid=0 on the next cycle.
